// File: rtl/id_issue_arbiter_pkg.sv
// Shared types for the ID->issue arbiter slice.
// Holds the FSM state enum, the source enum and the default starvation limit.
package id_issue_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic {
    SRC_FETCH  = 1'b0,
    SRC_INJECT = 1'b1
  } src_e;

  localparam int unsigned STARVE_LIMIT_DEF = 8;

endpackage

// File: rtl/id_issue_starve_cnt.sv
// Saturating starvation counter for the frontend requester.
// Ports: clk_i, rst_ni, inc_i, clr_i (wins over inc_i), hit_o = count at LIMIT.
module id_issue_starve_cnt
  import id_issue_arbiter_pkg::*;
#(
  parameter logic [7:0] LIMIT = 8'(STARVE_LIMIT_DEF)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic hit_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else if (clr_i) begin
      cnt_q <= 8'd0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign hit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/id_issue_arbiter.sv
// Two-requester arbiter + single-entry issue slot ahead of the issue stage.
// Ports: clk_i, rst_ni, flush_i; req0_* (decode), req1_* (inject, lock/last);
//   issue_valid_o/data_o/src_o, issue_ack_i; locked_o.
// Build option: ID_ISSUE_STARVE_GUARD_EN adds the req0 starvation guard.
module id_issue_arbiter
  import id_issue_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              req0_valid_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ready_o,
  input  logic              req1_lock_i,
  input  logic              req1_last_i,
  output logic              issue_valid_o,
  output logic [DATA_W-1:0] issue_data_o,
  output logic              issue_src_o,
  input  logic              issue_ack_i,
  output logic              locked_o
);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic              can_accept;
  logic              gnt0;
  logic              gnt1;
  logic              starve_hit;
  logic              slot_valid_q;
  logic [DATA_W-1:0] slot_data_q;
  src_e              slot_src_q;

  assign can_accept = !slot_valid_q || issue_ack_i;

  // Grants double as readies and are only raised for a valid requester,
  // so a grant is always a transferred beat.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    if (rst_ni && !flush_i && can_accept) begin
      case (state_q)
        ARB_IDLE: begin
          if (req0_valid_i && req1_valid_i) begin
            gnt0 = starve_hit;
            gnt1 = !starve_hit;
          end else begin
            gnt0 = req0_valid_i;
            gnt1 = req1_valid_i;
          end
        end
        ARB_LOCKED: begin
          gnt1 = req1_valid_i;
        end
        default: ;
      endcase
    end
    if (flush_i) begin
      state_d = ARB_IDLE;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (gnt1 && req1_lock_i && !req1_last_i) begin
            state_d = ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          if (gnt1 && req1_last_i) begin
            state_d = ARB_IDLE;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_valid_q <= 1'b0;
      slot_data_q  <= '0;
      slot_src_q   <= SRC_FETCH;
    end else if (flush_i) begin
      slot_valid_q <= 1'b0;
    end else if (gnt0 || gnt1) begin
      slot_valid_q <= 1'b1;
      slot_data_q  <= gnt1 ? req1_data_i : req0_data_i;
      slot_src_q   <= gnt1 ? SRC_INJECT : SRC_FETCH;
    end else if (issue_ack_i) begin
      slot_valid_q <= 1'b0;
    end
  end

`ifdef ID_ISSUE_STARVE_GUARD_EN
  logic in_idle;
  logic cnt_inc;
  logic cnt_clr;

  // The counter only moves in IDLE while the slot can take a beat;
  // a stalled slot or an active lock freezes it.
  assign in_idle = (state_q == ARB_IDLE);
  assign cnt_inc = !flush_i && in_idle && can_accept
                   && req0_valid_i && !gnt0;
  assign cnt_clr = flush_i || (in_idle && can_accept
                   && (gnt0 || !req0_valid_i));

  id_issue_starve_cnt #(
    .LIMIT (8'(STARVE_LIMIT))
  ) u_starve_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (cnt_inc),
    .clr_i  (cnt_clr),
    .hit_o  (starve_hit)
  );
`else
  logic unused_limit;

  assign unused_limit = |8'(STARVE_LIMIT);
  assign starve_hit   = 1'b0;
`endif

  assign req0_ready_o  = gnt0;
  assign req1_ready_o  = gnt1;
  assign issue_valid_o = slot_valid_q;
  assign issue_data_o  = slot_data_q;
  assign issue_src_o   = slot_src_q;
  assign locked_o      = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_id_issue_arbiter.sv
// Randomized + directed bench for id_issue_arbiter.
// Behavioural model of the slot, lock and starvation rules checked every cycle.
module tb_id_issue_arbiter;

  localparam int DW  = 64;
  localparam int LIM = 4;
`ifdef ID_ISSUE_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic          req0_valid_i = 1'b0;
  logic [DW-1:0] req0_data_i = '0;
  logic          req0_ready_o;
  logic          req1_valid_i = 1'b0;
  logic [DW-1:0] req1_data_i = '0;
  logic          req1_ready_o;
  logic          req1_lock_i = 1'b0;
  logic          req1_last_i = 1'b0;
  logic          issue_valid_o;
  logic [DW-1:0] issue_data_o;
  logic          issue_src_o;
  logic          issue_ack_i = 1'b0;
  logic          locked_o;

  id_issue_arbiter #(
    .DATA_W       (DW),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .req0_valid_i  (req0_valid_i),
    .req0_data_i   (req0_data_i),
    .req0_ready_o  (req0_ready_o),
    .req1_valid_i  (req1_valid_i),
    .req1_data_i   (req1_data_i),
    .req1_ready_o  (req1_ready_o),
    .req1_lock_i   (req1_lock_i),
    .req1_last_i   (req1_last_i),
    .issue_valid_o (issue_valid_o),
    .issue_data_o  (issue_data_o),
    .issue_src_o   (issue_src_o),
    .issue_ack_i   (issue_ack_i),
    .locked_o      (locked_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  bit          m_valid;
  bit          m_src;
  bit          m_locked;
  logic [DW-1:0] m_data;
  int          m_cnt;
  bit          e_r0;
  bit          e_r1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_valid  = 0;
    m_src    = 0;
    m_locked = 0;
    m_data   = '0;
    m_cnt    = 0;
  endfunction

  function automatic void predict();
    bit can;
    can  = !m_valid || issue_ack_i;
    e_r0 = 0;
    e_r1 = 0;
    if (flush_i || !can) begin
      e_r0 = 0;
    end else if (m_locked) begin
      e_r1 = req1_valid_i;
    end else if (req0_valid_i && req1_valid_i) begin
      if (GUARD && m_cnt == LIM) e_r0 = 1;
      else e_r1 = 1;
    end else begin
      e_r0 = req0_valid_i;
      e_r1 = req1_valid_i;
    end
  endfunction

  function automatic void step();
    bit can;
    bit b0;
    bit b1;
    can = !m_valid || issue_ack_i;
    b0  = req0_valid_i && e_r0;
    b1  = req1_valid_i && e_r1;
    if (flush_i) m_cnt = 0;
    else if (m_locked || !can) m_cnt = m_cnt;
    else if (b0 || !req0_valid_i) m_cnt = 0;
    else if (m_cnt < LIM) m_cnt++;
    if (flush_i) m_locked = 0;
    else if (!m_locked && b1 && req1_lock_i && !req1_last_i) m_locked = 1;
    else if (m_locked && b1 && req1_last_i) m_locked = 0;
    if (flush_i) begin
      m_valid = 0;
    end else if (b0 || b1) begin
      m_valid = 1;
      m_data  = b1 ? req1_data_i : req0_data_i;
      m_src   = b1;
    end else if (issue_ack_i) begin
      m_valid = 0;
    end
  endfunction

  task automatic cycle(input bit v0, input logic [DW-1:0] d0,
                       input bit v1, input logic [DW-1:0] d1,
                       input bit lk, input bit ls,
                       input bit ak, input bit fl);
    @(negedge clk);
    chk("issue_valid", issue_valid_o, m_valid);
    chk("locked", locked_o, m_locked);
    if (m_valid) begin
      chk("issue_data", issue_data_o, m_data);
      chk("issue_src", issue_src_o, m_src);
    end
    req0_valid_i = v0;
    req0_data_i  = d0;
    req1_valid_i = v1;
    req1_data_i  = d1;
    req1_lock_i  = lk;
    req1_last_i  = ls;
    issue_ack_i  = ak;
    flush_i      = fl;
    #1;
    predict();
    chk("req0_ready", req0_ready_o, e_r0);
    chk("req1_ready", req1_ready_o, e_r1);
    step();
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  initial begin
    model_reset();
    req0_valid_i = 1;
    req1_valid_i = 1;
    #2;
    chk("rst_valid", issue_valid_o, 0);
    chk("rst_data", issue_data_o, 0);
    chk("rst_src", issue_src_o, 0);
    chk("rst_locked", locked_o, 0);
    chk("rst_r0", req0_ready_o, 0);
    chk("rst_r1", req1_ready_o, 0);
    req0_valid_i = 0;
    req1_valid_i = 0;
    #10;
    rst_ni = 1;

    // req0 alone, continuous ack
    for (int i = 0; i < 3; i++) begin
      cycle(1, 64'h11, 0, '0, 0, 0, 1, 0);
      chk("r0_only_rdy", req0_ready_o, 1);
      @(posedge clk);
      #1;
      chk("r0_only_valid", issue_valid_o, 1);
      chk("r0_only_data", issue_data_o, 64'h11);
      chk("r0_only_src", issue_src_o, 0);
    end
    cycle(0, '0, 0, '0, 0, 0, 1, 0);

    // both valid: starvation pattern
    for (int i = 0; i < 10; i++) begin
      cycle(1, rnd(), 1, rnd(), 0, 0, 1, 0);
      chk("starve_r0", req0_ready_o, (GUARD && (i % 5) == 4) ? 1 : 0);
    end
    cycle(0, '0, 0, '0, 0, 0, 1, 0);

    // locked sequence of 5 beats
    cycle(1, rnd(), 1, 64'hA0, 1, 0, 1, 0);
    chk("lock_r0_first", req0_ready_o, 0);
    @(posedge clk);
    #1;
    chk("lock_rise", locked_o, 1);
    for (int i = 1; i < 5; i++) begin
      cycle(1, rnd(), 1, 64'hA0 + i, 0, (i == 4), 1, 0);
      chk("lock_r0", req0_ready_o, 0);
      chk("lock_r1", req1_ready_o, 1);
      @(posedge clk);
      #1;
      chk("lock_state", locked_o, (i != 4));
    end
    cycle(0, '0, 0, '0, 0, 0, 1, 0);

    // slot full stall, then ack with replacement
    cycle(1, 64'h55, 0, '0, 0, 0, 1, 0);
    cycle(1, 64'h66, 1, 64'h77, 0, 0, 0, 0);
    chk("stall_r0", req0_ready_o, 0);
    chk("stall_r1", req1_ready_o, 0);
    @(posedge clk);
    #1;
    chk("stall_data", issue_data_o, 64'h55);
    cycle(1, 64'h88, 0, '0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    chk("replace_valid", issue_valid_o, 1);
    chk("replace_data", issue_data_o, 64'h88);

    // flush while locked with ack+beat pending
    cycle(0, '0, 1, 64'hB1, 1, 0, 1, 0);
    cycle(1, rnd(), 1, 64'hB2, 0, 1, 1, 1);
    chk("flush_r1", req1_ready_o, 0);
    @(posedge clk);
    #1;
    chk("flush_valid", issue_valid_o, 0);
    chk("flush_locked", locked_o, 0);

    // asynchronous reset mid-lock
    cycle(0, '0, 1, 64'hC1, 1, 0, 1, 0);
    @(posedge clk);
    #3;
    rst_ni = 0;
    #1;
    model_reset();
    chk("arst_valid", issue_valid_o, 0);
    chk("arst_data", issue_data_o, 0);
    chk("arst_locked", locked_o, 0);
    chk("arst_r1", req1_ready_o, 0);
    req1_valid_i = 0;
    issue_ack_i  = 0;
    rst_ni = 1;
    cycle(1, 64'hD0, 1, rnd(), 0, 0, 0, 0);
    chk("post_rst_r0", req0_ready_o, GUARD ? 0 : 0);
    cycle(1, 64'hD1, 0, '0, 0, 0, 1, 0);
    chk("post_rst_r0_solo", req0_ready_o, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 10) < 7, rnd(),
            ($urandom % 2) == 1, rnd(),
            ($urandom % 10) < 3, ($urandom % 10) < 4,
            ($urandom % 10) < 7, ($urandom % 100) < 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
